// File: rtl/instr_encoder_if.sv
// Handshake bundle for instr_encoder.
//   Field input : in_valid/in_ready plus in_op, in_rs1, in_rs2, in_rd, in_gen, in_target
//   Memory write: imem_valid/imem_ready plus imem_addr, imem_wdata
// master = program source / instruction memory side, slave = encoder.
// Widths come from `INDEX_BIT and `INSTR_BIT (normally CONSTANT.v); the
// fallbacks below match the reference configuration.
`ifndef INDEX_BIT
`define INDEX_BIT 5
`endif
`ifndef INSTR_BIT
`define INSTR_BIT 8
`endif

interface instr_encoder_if;
    logic                        in_valid;
    logic                        in_ready;
    logic [2:0]                  in_op;
    logic [`INDEX_BIT-1:0]       in_rs1;
    logic [`INDEX_BIT-1:0]       in_rs2;
    logic [`INDEX_BIT-1:0]       in_rd;
    logic [28-3*`INDEX_BIT:0]    in_gen;
    logic [`INSTR_BIT-1:0]       in_target;
    logic                        imem_valid;
    logic                        imem_ready;
    logic [`INSTR_BIT-1:0]       imem_addr;
    logic [31:0]                 imem_wdata;

    modport master (
        output in_valid, in_op, in_rs1, in_rs2, in_rd, in_gen, in_target,
        input  in_ready,
        input  imem_valid, imem_addr, imem_wdata,
        output imem_ready
    );

    modport slave (
        input  in_valid, in_op, in_rs1, in_rs2, in_rd, in_gen, in_target,
        output in_ready,
        output imem_valid, imem_addr, imem_wdata,
        input  imem_ready
    );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: packs instruction fields into 32-bit words and writes them
// sequentially into instruction memory starting at address 0.
//   clk, rst       : rising-edge clock, synchronous active-high reset
//   start          : begins a new program load (ignored while running)
//   bus (slave)    : field-input handshake and memory-write handshake
//   busy           : high while loading
//   done           : program ended with a done word
//   overflow       : sticky, memory filled without a done word
//   prog_len       : number of words written
//   checksum       : running XOR of written words when ENCODER_CHECKSUM_EN
//                    is defined, otherwise tied to 0
// A single output register holds the word being written; a new field set
// can be accepted in the same cycle the held word is written.
`ifndef INDEX_BIT
`define INDEX_BIT 5
`endif
`ifndef INSTR_BIT
`define INSTR_BIT 8
`endif

module instr_encoder (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    instr_encoder_if.slave        bus,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [`INSTR_BIT:0]   prog_len,
    output logic [31:0]           checksum
);
    localparam int AB = `INSTR_BIT;
    localparam logic [AB-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {IDLE, RUN, FINISHED} state_t;

    state_t          state, state_nxt;
    logic            wvalid;
    logic [AB-1:0]   waddr;
    logic [31:0]     wdata;
    logic            pend_done;
    logic            last_pending;
    logic            wr_fire;
    logic            accept;
    logic            restart;
    logic [31:0]     enc_word;

    assign bus.imem_valid = wvalid;
    assign bus.imem_addr  = waddr;
    assign bus.imem_wdata = wdata;

    // waddr always points at the next slot to write, so the held word sits
    // at waddr; the final word of a program blocks further accepts.
    assign last_pending = wvalid && (pend_done || waddr == LAST_ADDR);
    assign wr_fire      = wvalid && bus.imem_ready;
    assign bus.in_ready = (state == RUN) && (!wvalid || bus.imem_ready) && !last_pending;
    assign accept       = bus.in_valid && bus.in_ready;
    assign restart      = start && (state != RUN);
    assign busy         = (state == RUN);

    always_comb begin
        enc_word = {bus.in_op, bus.in_rs1, bus.in_rs2, bus.in_rd, bus.in_gen};
        if (bus.in_op == 3'b111)
            enc_word = {3'b111, 29'b0};
        else if (bus.in_op == 3'b110)
            enc_word = {3'b110, bus.in_target, {(29-AB){1'b0}}};
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (start) state_nxt = RUN;
            // writing the last pending word (done or last address) ends the load
            RUN:      if (wr_fire && last_pending) state_nxt = FINISHED;
            FINISHED: if (start) state_nxt = RUN;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wvalid    <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
            pend_done <= 1'b0;
            prog_len  <= '0;
            done      <= 1'b0;
            overflow  <= 1'b0;
        end else if (restart) begin
            // discard any buffered word and restart at address 0
            wvalid    <= 1'b0;
            waddr     <= '0;
            pend_done <= 1'b0;
            prog_len  <= '0;
            done      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (wr_fire) begin
                waddr    <= waddr + AB'(1);
                prog_len <= prog_len + (AB+1)'(1);
                if (pend_done)
                    done <= 1'b1;
                else if (waddr == LAST_ADDR)
                    overflow <= 1'b1;
            end
            if (accept) begin
                wvalid    <= 1'b1;
                wdata     <= enc_word;
                pend_done <= (bus.in_op == 3'b111);
            end else if (wr_fire) begin
                wvalid    <= 1'b0;
            end
        end
    end

`ifdef ENCODER_CHECKSUM_EN
    logic [31:0] csum;
    always_ff @(posedge clk) begin
        if (rst || restart) csum <= '0;
        else if (wr_fire)   csum <= csum ^ wdata;
    end
    assign checksum = csum;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus random
// traffic against a queue-based reference model of the expected writes.
`ifndef INDEX_BIT
`define INDEX_BIT 5
`endif
`ifndef INSTR_BIT
`define INSTR_BIT 8
`endif

module tb_instr_encoder;
    localparam int IB = `INDEX_BIT;
    localparam int AB = `INSTR_BIT;
    localparam int GW = 29 - 3*IB;
    localparam int ADDR_MAX = (1 << AB) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            busy, done, overflow;
    logic [AB:0]     prog_len;
    logic [31:0]     checksum;

    instr_encoder_if bus();

    instr_encoder dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus),
        .busy(busy), .done(done), .overflow(overflow),
        .prog_len(prog_len), .checksum(checksum)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          addr;
        logic [31:0] word;
        bit          dn;
    } ent_t;

    ent_t        q[$];
    bit          m_run  = 0;
    bit          m_done = 0;
    bit          m_ovf  = 0;
    int          m_acc  = 0;
    int          m_wr   = 0;
    logic [31:0] m_csum = '0;
    bit          last_acc;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] held;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [2:0] op, input logic [IB-1:0] r1,
                                        input logic [IB-1:0] r2, input logic [IB-1:0] rd,
                                        input logic [GW-1:0] g, input logic [AB-1:0] t);
        if (op == 3'd7) return 32'(7) << 29;
        if (op == 3'd6) return (32'(6) << 29) | (32'(t) << (29 - AB));
        return (32'(op) << 29) | (32'(r1) << (29 - IB)) | (32'(r2) << (29 - 2*IB))
             | (32'(rd) << (29 - 3*IB)) | 32'(g);
    endfunction

    task automatic model_clear(input bit run);
        q.delete();
        m_run = run; m_done = 0; m_ovf = 0;
        m_acc = 0; m_wr = 0; m_csum = '0;
    endtask

    // Checks every output at the falling edge, then advances the model
    // across the next rising edge using handshakes derived from the model.
    task automatic tick();
        bit pend, lastp, exp_rdy, wr, acc, st, r, was_run;
        ent_t e;
        logic [31:0] exp_cs;
        #4;
        pend    = (q.size() != 0);
        lastp   = pend && (q[0].dn || q[0].addr == ADDR_MAX);
        exp_rdy = m_run && (!pend || bus.imem_ready) && !lastp;
        chk("in_ready", bus.in_ready, exp_rdy);
        chk("imem_valid", bus.imem_valid, pend);
        if (pend) begin
            chk("imem_addr", bus.imem_addr, q[0].addr % (ADDR_MAX + 1));
            chk("imem_wdata", bus.imem_wdata, q[0].word);
        end
        chk("busy", busy, m_run);
        chk("done", done, m_done);
        chk("overflow", overflow, m_ovf);
        chk("prog_len", prog_len, m_wr);
`ifdef ENCODER_CHECKSUM_EN
        exp_cs = m_csum;
`else
        exp_cs = '0;
`endif
        chk("checksum", checksum, exp_cs);
        wr = pend && bus.imem_ready;
        acc = exp_rdy && bus.in_valid;
        e.addr = m_acc;
        e.word = enc(bus.in_op, bus.in_rs1, bus.in_rs2, bus.in_rd, bus.in_gen, bus.in_target);
        e.dn   = (bus.in_op == 3'd7);
        st = start; r = rst; was_run = m_run;
        @(posedge clk); #1;
        last_acc = acc;
        if (r) model_clear(0);
        else if (st && !was_run) model_clear(1);
        else begin
            if (wr) begin
                m_wr++;
                m_csum ^= q[0].word;
                if (q[0].dn) begin m_done = 1; m_run = 0; end
                else if (q[0].addr == ADDR_MAX) begin m_ovf = 1; m_run = 0; end
                void'(q.pop_front());
            end
            if (acc) begin q.push_back(e); m_acc++; end
        end
    endtask

    task automatic fields(input logic [2:0] op, input logic [IB-1:0] r1, input logic [IB-1:0] r2,
                          input logic [IB-1:0] rd, input logic [GW-1:0] g, input logic [AB-1:0] t);
        bus.in_op = op; bus.in_rs1 = r1; bus.in_rs2 = r2; bus.in_rd = rd;
        bus.in_gen = g; bus.in_target = t;
    endtask

    task automatic rnd_fields(input logic [2:0] op);
        fields(op, IB'($urandom), IB'($urandom), IB'($urandom), GW'($urandom), AB'($urandom));
    endtask

    // Holds in_valid until the word is accepted (bounded).
    task automatic send(input logic [2:0] op, input logic [IB-1:0] r1, input logic [IB-1:0] r2,
                        input logic [IB-1:0] rd, input logic [GW-1:0] g, input logic [AB-1:0] t);
        bit got = 0;
        fields(op, r1, r2, rd, g, t);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 64 && !got; i++) begin
            tick();
            got = last_acc;
        end
        if (!got) chk("accept_timeout", 0, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        bus.in_valid = 1'b0; bus.imem_ready = 1'b0;
        fields(3'd0, '0, '0, '0, '0, '0);
        @(posedge clk); #1;
        tick();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_valid", bus.imem_valid, 0);
        chk("rst_addr", bus.imem_addr, 0);
        chk("rst_wdata", bus.imem_wdata, 0);
        chk("rst_len", prog_len, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_cs", checksum, 0);
        tick();
        chk("idle_ready", bus.in_ready, 0);

        // encode op 000 and finish with a done word
        bus.imem_ready = 1'b1;
        pulse_start();
        send(3'd0, 5'd1, 5'd2, 5'd3, '0, AB'($urandom));
        chk("s1_valid", bus.imem_valid, 1);
        chk("s1_addr", bus.imem_addr, 0);
        chk("s1_wdata", bus.imem_wdata, 32'h0110C000);
        send(3'd7, IB'($urandom), IB'($urandom), IB'($urandom), GW'($urandom), AB'($urandom));
        tick();
        chk("s1_done", done, 1);
`ifdef ENCODER_CHECKSUM_EN
        chk("s1_checksum", checksum, 32'hE110C000);
`else
        chk("s1_checksum", checksum, 32'h0);
`endif

        // restart from FINISHED: jump then done
        pulse_start();
        chk("s2_cleared", {done, prog_len}, 0);
        send(3'd6, IB'($urandom), IB'($urandom), IB'($urandom), GW'($urandom), 8'h25);
        chk("s2_jump_addr", bus.imem_addr, 0);
        chk("s2_jump_word", bus.imem_wdata, 32'hC4A00000);
        send(3'd7, '0, '0, '0, '0, '0);
        chk("s2_done_addr", bus.imem_addr, 1);
        chk("s2_done_word", bus.imem_wdata, 32'hE0000000);
        tick();
        chk("s2_done", done, 1);
        chk("s2_len", prog_len, 2);
        chk("s2_ready", bus.in_ready, 0);

        // back-pressure: word held stable for 3 cycles, start ignored in RUN
        pulse_start();
        bus.imem_ready = 1'b0;
        rnd_fields(3'($urandom_range(0, 5)));
        send(bus.in_op, bus.in_rs1, bus.in_rs2, bus.in_rd, bus.in_gen, bus.in_target);
        held = bus.imem_wdata;
        rnd_fields(3'd1);
        bus.in_valid = 1'b1;
        start = 1'b1;
        repeat (3) tick();
        start = 1'b0;
        chk("stall_wdata", bus.imem_wdata, held);
        chk("stall_addr", bus.imem_addr, 0);
        chk("stall_len", prog_len, 0);
        bus.in_valid = 1'b0;
        bus.imem_ready = 1'b1;
        repeat (3) tick();
        chk("stall_written_once", prog_len, 1);

        // overflow: stream non-done words until the memory is full
        do_reset();
        pulse_start();
        for (int i = 0; i < 2000 && m_run; i++) begin
            rnd_fields(3'($urandom_range(0, 6)));
            bus.in_valid = ($urandom_range(0, 7) != 0);
            bus.imem_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        chk("ovf_flag", overflow, 1);
        chk("ovf_done", done, 0);
        chk("ovf_len", prog_len, 256);
        chk("ovf_busy", busy, 0);
        pulse_start();
        chk("ovf_restart_clear", {overflow, done, prog_len}, 0);
        bus.imem_ready = 1'b0;
        send(3'd2, IB'($urandom), IB'($urandom), IB'($urandom), GW'($urandom), '0);
        chk("ovf_restart_addr", bus.imem_addr, 0);

        // reset while a write is stalled, with start also high
        chk("rstmid_pending", bus.imem_valid, 1);
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        chk("rstmid_valid", bus.imem_valid, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_len", prog_len, 0);

        // random programs
        for (int i = 0; i < 4000; i++) begin
            rst   = ($urandom_range(0, 299) == 0);
            start = ($urandom_range(0, 24) == 0);
            rnd_fields(($urandom_range(0, 15) == 0) ? 3'd7 : 3'($urandom_range(0, 6)));
            bus.in_valid = ($urandom_range(0, 2) != 0);
            bus.imem_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        rst = 1'b0; start = 1'b0; bus.in_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
